// File: rtl/axi4lite_initiator_cmd.sv
// AXI4-Lite initiator: turns one local register command at a time into an AXI4-Lite
// write or read, returning a single response pulse. Optional abort: AXI4LITE_INIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | awvalid/wvalid outstanding, each drops on its own handshake
// WR_B  | bready high, waiting for the write response
// RD_A  | arvalid held until arready
// RD_D  | rready high, waiting for read data
module axi4lite_initiator_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        accept;

  assign accept = cmd_valid && cmd_ready_q;

`ifdef AXI4LITE_INIT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept)
      tmo_cnt_d = '0;
    else if (state_q != IDLE)
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_A;
          end
        end
      end
      WR: begin
        // address and data channels complete independently, in any order
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI4LITE_INIT_TIMEOUT_EN
    // a response completing in the expiry cycle takes priority over the abort
    if (state_q != IDLE && tmo_cnt_q == TMO_LAST && !rsp_valid_d) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_resp_d  = 2'b10;
      rsp_rdata_d = '0;
      cmd_ready_d = 1'b1;
      state_d     = IDLE;
    end
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign araddr    = araddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4lite_initiator_cmd.sv
// Bench for axi4lite_initiator_cmd: handshake-level model checked every cycle, a
// delay-programmable slave, and directed commands with literal response checks.
module tb_axi4lite_initiator_cmd;
  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 aclk = ~aclk;

  axi4lite_initiator_cmd #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // slave behaviour knobs
  int          s_aw = 0, s_w = 0, s_b = 0, s_ar = 0, s_r = 0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;

  initial begin : slave
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      end else begin
        awready = awvalid && (aw_c >= s_aw); aw_c = awvalid ? aw_c + 1 : 0;
        wready  = wvalid  && (w_c  >= s_w);  w_c  = wvalid  ? w_c + 1  : 0;
        arready = arvalid && (ar_c >= s_ar); ar_c = arvalid ? ar_c + 1 : 0;
        bvalid  = bready  && (b_c  >= s_b);  b_c  = bready  ? b_c + 1  : 0;
        rvalid  = rready  && (r_c  >= s_r);  r_c  = rready  ? r_c + 1  : 0;
        bresp = s_bresp; rresp = s_rresp; rdata = s_rdata;
      end
    end
  end

  // transaction-level model: one outstanding command tracked by which handshakes have happened
  bit          m_busy, m_wr, m_aw, m_w, m_ar, m_due;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [1:0]  m_resp;
  int          m_age, cyc = 0;
  int          acc_q[$], rsp_cyc_q[$];
  logic [31:0] log_rdata[$];
  logic [1:0]  log_resp[$];

  always @(negedge aclk) begin : cmp
    bit e_rdy, e_aw, e_w, e_b, e_ar, e_r, done;
    cyc++;
    if (!aresetn) begin
      m_busy = 0; m_due = 0; m_aw = 0; m_w = 0; m_ar = 0;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
      chk("rst_awaddr", awaddr, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", 32'(wstrb), 32'd0);
      chk("rst_rsp", rsp_rdata | 32'(rsp_resp), 32'd0);
    end else begin
      e_rdy = !m_busy;
      e_aw  = m_busy && m_wr && !m_aw;
      e_w   = m_busy && m_wr && !m_w;
      e_b   = m_busy && m_wr && m_aw && m_w;
      e_ar  = m_busy && !m_wr && !m_ar;
      e_r   = m_busy && !m_wr && m_ar;
      chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
      chk("awvalid", 32'(awvalid), 32'(e_aw));
      chk("wvalid", 32'(wvalid), 32'(e_w));
      chk("bready", 32'(bready), 32'(e_b));
      chk("arvalid", 32'(arvalid), 32'(e_ar));
      chk("rready", 32'(rready), 32'(e_r));
      if (e_aw) chk("awaddr", awaddr, m_addr);
      if (e_w) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb", 32'(wstrb), 32'(m_strb));
      end
      if (e_ar) chk("araddr", araddr, m_addr);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_due));
      if (m_due) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(m_resp));
      end
      if (rsp_valid) begin
        log_rdata.push_back(rsp_rdata);
        log_resp.push_back(rsp_resp);
        rsp_cyc_q.push_back(cyc);
      end
      m_due = 0;
      done = 0;
      if (m_busy) begin
        if (m_wr) begin
          if (e_aw && awready) m_aw = 1;
          if (e_w && wready) m_w = 1;
          if (e_b && bvalid) begin done = 1; m_resp = bresp; m_rdata = '0; end
        end else begin
          if (e_ar && arready) m_ar = 1;
          if (e_r && rvalid) begin done = 1; m_resp = rresp; m_rdata = rdata; end
        end
`ifdef AXI4LITE_INIT_TIMEOUT_EN
        if (!done) begin
          m_age++;
          if (m_age == TO) begin done = 1; m_resp = 2'b10; m_rdata = '0; end
        end
`endif
        if (done) begin m_busy = 0; m_due = 1; end
      end
      if (cmd_valid && e_rdy) begin
        m_busy = 1; m_wr = cmd_write; m_aw = 0; m_w = 0; m_ar = 0; m_age = 0;
        m_addr = cmd_addr; m_wdata = cmd_wdata; m_strb = cmd_wstrb;
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    s_aw = aw; s_w = w; s_b = b; s_ar = ar; s_r = r;
    s_bresp = br; s_rresp = rr; s_rdata = rd;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    wait_accept();
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk); #1;
      if (log_resp.size() >= n) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_timeout", 32'(log_resp.size()), 32'(n));
  endtask

  int n_rsp = 0;

  initial begin : stim
    repeat (3) @(negedge aclk);
    @(posedge aclk); #3 aresetn = 1;

    // zero-wait slave: both directions respond three cycles after acceptance
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
    issue(1, 32'h30, 32'h1122_3344, 4'h3); n_rsp++; wait_rsp(n_rsp);
    chk("lat_wr", 32'(rsp_cyc_q[0] - acc_q[0]), 32'd3);
    issue(0, 32'h34, 32'h0, 4'h0); n_rsp++; wait_rsp(n_rsp);
    chk("lat_rd", 32'(rsp_cyc_q[1] - acc_q[1]), 32'd3);
    chk("zw_rdata", log_rdata[1], 32'h0BAD_F00D);

    // write with wready one cycle after aw
    set_slave(0, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(1, 32'h10, 32'hA5A5_1234, 4'hF); n_rsp++; wait_rsp(n_rsp);
    chk("wr1_resp", 32'(log_resp[2]), 32'd0);
    chk("wr1_rdata", log_rdata[2], 32'd0);

    // read, arready after 2 cycles, data 3 cycles later
    set_slave(0, 0, 0, 2, 3, 2'b00, 2'b00, 32'hDEAD_BEEF);
    issue(0, 32'h24, 32'h0, 4'h0); n_rsp++; wait_rsp(n_rsp);
    chk("rd1_rdata", log_rdata[3], 32'hDEAD_BEEF);
    chk("rd1_resp", 32'(log_resp[3]), 32'd0);

    // wready three cycles ahead of awready
    set_slave(3, 0, 1, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(1, 32'h40, 32'hCAFE_0001, 4'h5); n_rsp++; wait_rsp(n_rsp);
    chk("wr_order_resp", 32'(log_resp[4]), 32'd0);

    // cmd_valid held across two writes
    set_slave(1, 1, 1, 0, 0, 2'b00, 2'b00, 32'h0);
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h00; cmd_wdata = 32'h1111_0000; cmd_wstrb = 4'h1;
    wait_accept();
    @(posedge aclk); #1;
    cmd_addr = 32'h04; cmd_wdata = 32'h2222_0000; cmd_wstrb = 4'hC;
    wait_accept();
    @(posedge aclk); #1;
    cmd_valid = 0;
    n_rsp += 2; wait_rsp(n_rsp);
    repeat (6) @(negedge aclk);
    chk("hold_pulses", 32'(log_resp.size()), 32'(n_rsp));
    chk("hold_acc_at_rsp", 32'(acc_q[6] - rsp_cyc_q[5]), 32'd0);

    // error responses pass through
    set_slave(1, 1, 1, 0, 0, 2'b10, 2'b00, 32'h0);
    issue(1, 32'h50, 32'h0000_00FF, 4'h1); n_rsp++; wait_rsp(n_rsp);
    set_slave(0, 0, 0, 1, 1, 2'b00, 2'b11, 32'h5555_AAAA);
    issue(0, 32'h54, 32'h0, 4'h0); n_rsp++; wait_rsp(n_rsp);
    chk("slverr_bresp", 32'(log_resp[7]), 32'd2);
    chk("decerr_rresp", 32'(log_resp[8]), 32'd3);
    chk("err_rdata", log_rdata[8], 32'h5555_AAAA);

`ifdef AXI4LITE_INIT_TIMEOUT_EN
    // arready never comes: abort 17 cycles after acceptance with SLVERR
    set_slave(0, 0, 0, 100000, 0, 2'b00, 2'b00, 32'h1234_5678);
    issue(0, 32'h60, 32'h0, 4'h0); n_rsp++; wait_rsp(n_rsp);
    chk("tmo_resp", 32'(log_resp[n_rsp-1]), 32'd2);
    chk("tmo_rdata", log_rdata[n_rsp-1], 32'd0);
    chk("tmo_latency", 32'(rsp_cyc_q[n_rsp-1] - acc_q[n_rsp-1]), 32'(TO + 1));
`endif

    // reset in the middle of a write: valids drop at once, no response
    set_slave(50, 50, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    issue(1, 32'h70, 32'h7777_7777, 4'hF);
    repeat (2) @(posedge aclk);
    #3 aresetn = 0;
    #1;
    chk("rst_mid_awvalid", 32'(awvalid), 32'd0);
    chk("rst_mid_wvalid", 32'(wvalid), 32'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1;
    repeat (10) @(negedge aclk);
    chk("rst_mid_no_rsp", 32'(log_resp.size()), 32'(n_rsp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "time limit");
  end

endmodule
